// File: rtl/regfile_pkg.sv
// Shared constants and clear-sweep state encoding for the multi-port register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a (types and constants only).
package regfile_pkg;

    // Default geometry: 32 x 32-bit registers, two read ports.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    // Clear sweep state machine encoding.
    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clearState_t;

    // Number of registers addressed by an address of the given width.
    function automatic int depthOf(input int addrW);
        return 1 << addrW;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Background clear sweep controller: walks registers 1..DEPTH-1, one per cycle.
// Latency: busy the cycle after Clear is sampled, done pulse DEPTH cycles after it.
// Backpressure: none taken; ClearBusy tells the write side to drop and stall.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Clear,
    output logic              ClearBusy,
    output logic              ClearDone,
    output logic              ClearStrobe,
    output logic [ADDR_W-1:0] ClearAddr
);

    // Last register touched by the sweep; the index never wraps past it.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(depthOf(ADDR_W) - 1);

    clearState_t       state;
    logic [ADDR_W-1:0] index;

    // Sweep sequencing: Clear in IDLE starts at register 1, Clear during SWEEP is ignored,
    // and the final register clears on the same edge that returns to IDLE and raises done.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            index     <= '0;
            ClearBusy <= 1'b0;
            ClearDone <= 1'b0;
        end else begin
            ClearDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (Clear) begin
                        state     <= SWEEP;
                        index     <= ADDR_W'(1);
                        ClearBusy <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (index == LAST_IDX) begin
                        state     <= IDLE;
                        ClearBusy <= 1'b0;
                        ClearDone <= 1'b1;
                    end else begin
                        index <= index + ADDR_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    ClearBusy <= 1'b0;
                end
            endcase
        end
    end

    // The storage zeroes the indexed register on every edge spent in SWEEP.
    assign ClearStrobe = (state == SWEEP);
    assign ClearAddr   = index;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with zero register and background clear sweep.
// Latency: reads combinational; writes visible next cycle (same cycle with REGFILE_BYPASS_EN).
// Backpressure: writes silently dropped while ClearBusy is high; upstream stalls on it.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     WrEnA,
    input  logic [ADDR_W-1:0]        WrAddrA,
    input  logic [DATA_W-1:0]        WrDataA,
    input  logic                     WrEnB,
    input  logic [ADDR_W-1:0]        WrAddrB,
    input  logic [DATA_W-1:0]        WrDataB,
    input  logic [NUM_RD*ADDR_W-1:0] ReadAddr,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    input  logic                     Clear,
    output logic                     ClearBusy,
    output logic                     ClearDone
);

    localparam int DEPTH = depthOf(ADDR_W);

    logic [DATA_W-1:0] registers [DEPTH];

    logic              clearStrobe;
    logic [ADDR_W-1:0] clearAddr;
    logic              wrAcceptA;
    logic              wrAcceptB;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) uClearFsm (
        .Clock       (Clock),
        .Reset       (Reset),
        .Clear       (Clear),
        .ClearBusy   (ClearBusy),
        .ClearDone   (ClearDone),
        .ClearStrobe (clearStrobe),
        .ClearAddr   (clearAddr)
    );

    // A write lands only for a nonzero address while no sweep is running.
    assign wrAcceptA = WrEnA && (WrAddrA != '0) && !ClearBusy;
    assign wrAcceptB = WrEnB && (WrAddrB != '0) && !ClearBusy;

    // Storage update: reset clears everything, the sweep zeroes one entry per cycle,
    // otherwise port B is applied after port A so B wins on an address collision.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                registers[i] <= '0;
            end
        end else if (clearStrobe) begin
            registers[clearAddr] <= '0;
        end else begin
            if (wrAcceptA) begin
                registers[WrAddrA] <= WrDataA;
            end
            if (wrAcceptB) begin
                registers[WrAddrB] <= WrDataB;
            end
        end
    end

    // Read muxing per port: stored value, optionally overridden by a same-cycle accepted
    // write (B checked last so it beats A), and forced to zero for register 0.
    always_comb begin
        logic [ADDR_W-1:0] rdAddr;
        logic [DATA_W-1:0] rdVal;
        ReadData = '0;
        rdAddr   = '0;
        rdVal    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rdAddr = ReadAddr[k*ADDR_W +: ADDR_W];
            rdVal  = registers[rdAddr];
`ifdef REGFILE_BYPASS_EN
            if (wrAcceptA && (WrAddrA == rdAddr)) begin
                rdVal = WrDataA;
            end
            if (wrAcceptB && (WrAddrB == rdAddr)) begin
                rdVal = WrDataB;
            end
`else
            // Without bypass a same-cycle write only shows up after the commit edge.
`endif
            if (rdAddr == '0) begin
                rdVal = '0;
            end
            ReadData[k*DATA_W +: DATA_W] = rdVal;
        end
    end

endmodule
